// File: rtl/rc4_key_search_ctrl_pkg.sv
// rc4_pkg
// Shared constants for the RC4 key-search controller slice.
//   - FSM state codes (plain 4-bit constants so older blocks can reuse them)
//   - S-memory port-owner encodings driven on mem_sel
//   - Printable-character bounds used by the plaintext checker
package rc4_pkg;

   // Controller states
   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_RUN_INIT  = 4'd1;
   localparam logic [3:0] ST_WAIT_INIT = 4'd2;
   localparam logic [3:0] ST_RUN_KSA   = 4'd3;
   localparam logic [3:0] ST_WAIT_KSA  = 4'd4;
   localparam logic [3:0] ST_RUN_DEC   = 4'd5;
   localparam logic [3:0] ST_WAIT_DEC  = 4'd6;
   localparam logic [3:0] ST_CHECK     = 4'd7;
   localparam logic [3:0] ST_NEXT_KEY  = 4'd8;
   localparam logic [3:0] ST_FOUND     = 4'd9;
   localparam logic [3:0] ST_EXHAUSTED = 4'd10;

   // Owner of the shared S-memory port
   localparam logic [1:0] SEL_INIT = 2'd0;
   localparam logic [1:0] SEL_KSA  = 2'd1;
   localparam logic [1:0] SEL_DEC  = 2'd2;
   localparam logic [1:0] SEL_NONE = 2'd3;

   // A plaintext byte is acceptable if it is a space or a lowercase letter
   localparam logic [7:0] CHAR_SPACE = 8'h20;
   localparam logic [7:0] CHAR_LO    = 8'h61;
   localparam logic [7:0] CHAR_HI    = 8'h7A;

endpackage

// File: rtl/rc4_key_search_ctrl_if.sv
// rc4_key_search_ctrl_if
// Bundles the controller's handshake with the board logic and the engines.
//   master : the controller (drives start pulses, eng_reset, mem_sel, key, status)
//   slave  : board logic + engines (drive start/abort, done flags, plaintext)
interface rc4_key_search_ctrl_if #(
   parameter int KEY_WIDTH = 24,
   parameter int MSG_DEP   = 32,
   parameter int MSG_WIDTH = 8
);
   logic start;
   logic abort;
   logic init_done;
   logic ksa_done;
   logic dec_done;
   logic [MSG_DEP-1:0][MSG_WIDTH-1:0] decrypted_output;
   logic init_start;
   logic ksa_start;
   logic dec_start;
   logic eng_reset;
   logic [1:0] mem_sel;
   logic [KEY_WIDTH-1:0] secret_key;
   logic busy;
   logic found;
   logic exhausted;

   modport master (
      input  start, abort, init_done, ksa_done, dec_done, decrypted_output,
      output init_start, ksa_start, dec_start, eng_reset, mem_sel,
             secret_key, busy, found, exhausted
   );

   modport slave (
      output start, abort, init_done, ksa_done, dec_done, decrypted_output,
      input  init_start, ksa_start, dec_start, eng_reset, mem_sel,
             secret_key, busy, found, exhausted
   );

endinterface

// File: rtl/rc4_key_search_ctrl_checker.sv
// plaintext_byte_checker
// Combinational test of one decrypted byte.
//   data_byte : byte under test (MSG_WIDTH bits)
//   valid     : high when the byte is a space or lies in 'a'..'z'
module plaintext_byte_checker
   import rc4_pkg::*;
#(
   parameter int MSG_WIDTH = 8
) (
   input  logic [MSG_WIDTH-1:0] data_byte,
   output logic                 valid
);

   // Range test against the character bounds, widened to the byte width
   always_comb begin
      valid = (data_byte == MSG_WIDTH'(CHAR_SPACE)) ||
              ((data_byte >= MSG_WIDTH'(CHAR_LO)) && (data_byte <= MSG_WIDTH'(CHAR_HI)));
   end

endmodule

// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl
// Sequencer for the brute-force RC4 key search. For each candidate key it
// runs S-init, key-schedule and decrypt in turn, scans the plaintext one byte
// per cycle, and either stops on a readable message or moves to the next key.
//   clk    : system clock
//   reset  : synchronous, active-low
//   bus    : master side of rc4_key_search_ctrl_if (start/abort, engine
//            start/done handshakes, eng_reset, mem_sel, secret_key, status)
module rc4_key_search_ctrl
   import rc4_pkg::*;
#(
   parameter int                   KEY_WIDTH = 24,
   parameter logic [KEY_WIDTH-1:0] KEY_LAST  = 24'h3F_FFFF,
   parameter int                   MSG_DEP   = 32,
   parameter int                   MSG_WIDTH = 8
) (
   input logic                   clk,
   input logic                   reset,
   rc4_key_search_ctrl_if.master bus
);

   localparam int K_W = (MSG_DEP > 1) ? $clog2(MSG_DEP) : 1;

   logic [3:0]     state;
   logic [K_W-1:0] k;
   logic           byte_valid;

   // One checker, steered by the scan index
   plaintext_byte_checker #(
      .MSG_WIDTH (MSG_WIDTH)
   ) u_checker (
      .data_byte (bus.decrypted_output[k]),
      .valid     (byte_valid)
   );

   // Main FSM. Every output is a register: start pulses and mem_sel change on
   // the same edge that enters a RUN state, so engines see a settled select
   // before they touch memory. Pulses default low each cycle; abort outranks
   // any done flag arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state          <= ST_IDLE;
         k              <= '0;
         bus.init_start <= 1'b0;
         bus.ksa_start  <= 1'b0;
         bus.dec_start  <= 1'b0;
         bus.eng_reset  <= 1'b1;
         bus.mem_sel    <= SEL_NONE;
         bus.secret_key <= '0;
         bus.busy       <= 1'b0;
         bus.found      <= 1'b0;
         bus.exhausted  <= 1'b0;
      end else begin
         bus.init_start <= 1'b0;
         bus.ksa_start  <= 1'b0;
         bus.dec_start  <= 1'b0;
         bus.eng_reset  <= 1'b0;
         if ((state != ST_IDLE) && bus.abort) begin
            state          <= ST_IDLE;
            k              <= '0;
            bus.eng_reset  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.mem_sel    <= SEL_NONE;
            bus.secret_key <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.start) begin
                     state          <= ST_RUN_INIT;
                     k              <= '0;
                     bus.init_start <= 1'b1;
                     bus.mem_sel    <= SEL_INIT;
                     bus.secret_key <= '0;
                     bus.busy       <= 1'b1;
                     bus.found      <= 1'b0;
                     bus.exhausted  <= 1'b0;
                  end
               end
               ST_RUN_INIT: state <= ST_WAIT_INIT;
               ST_WAIT_INIT: begin
                  if (bus.init_done) begin
                     state         <= ST_RUN_KSA;
                     bus.ksa_start <= 1'b1;
                     bus.mem_sel   <= SEL_KSA;
                  end
               end
               ST_RUN_KSA: state <= ST_WAIT_KSA;
               ST_WAIT_KSA: begin
                  if (bus.ksa_done) begin
                     state         <= ST_RUN_DEC;
                     bus.dec_start <= 1'b1;
                     bus.mem_sel   <= SEL_DEC;
                  end
               end
               ST_RUN_DEC: state <= ST_WAIT_DEC;
               ST_WAIT_DEC: begin
                  if (bus.dec_done) begin
                     state       <= ST_CHECK;
                     k           <= '0;
                     bus.mem_sel <= SEL_NONE;
                  end
               end
               ST_CHECK: begin
                  if (!byte_valid) begin
                     state         <= ST_NEXT_KEY;
                     k             <= '0;
                     bus.eng_reset <= 1'b1;
                  end else if (k == K_W'(MSG_DEP - 1)) begin
                     state     <= ST_FOUND;
                     k         <= '0;
                     bus.found <= 1'b1;
                     bus.busy  <= 1'b0;
                  end else begin
                     k <= k + K_W'(1);
                  end
               end
               ST_NEXT_KEY: begin
                  if (bus.secret_key == KEY_LAST) begin
                     state         <= ST_EXHAUSTED;
                     bus.exhausted <= 1'b1;
                     bus.busy      <= 1'b0;
                  end else begin
                     state          <= ST_RUN_INIT;
                     bus.secret_key <= bus.secret_key + KEY_WIDTH'(1);
                     bus.init_start <= 1'b1;
                     bus.mem_sel    <= SEL_INIT;
                  end
               end
               ST_FOUND, ST_EXHAUSTED: begin
                  if (bus.start) begin
                     state <= ST_IDLE;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// tb_rc4_key_search_ctrl
// Self-checking bench: simple 3-cycle engine models, a key-dependent plaintext
// model, a table of checker boundary vectors and hand-written sequences for
// abort and mid-search reset. KEY_LAST is 5 so found-at-last-key and
// exhaustion both finish quickly.
module tb_rc4_key_search_ctrl;
   import rc4_pkg::*;

   localparam int               KW    = 24;
   localparam int               DEP   = 32;
   localparam int               MW    = 8;
   localparam logic [KW-1:0]    KLAST = 24'd5;

   typedef struct {
      logic [7:0] val;
      int         idx;
      bit         expFound;
      int         expCheck;
   } vec_t;

   typedef struct {
      bit expFound;
      int expCheck;
   } exp_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   int   validKey;
   int   badIdx;
   logic [7:0] badVal;
   logic [KW-1:0] keyQ[$];
   exp_t expQ[$];
   vec_t vecs[8];
   int nInit, nKsa, nDec, nEngRst, nCheck, nOverlap;
   bit finished;
   logic [2:0] startVec;
   logic [2:0] doneVec;
   logic       engRun[3];
   logic [1:0] engCnt[3];

   rc4_key_search_ctrl_if #(.KEY_WIDTH(KW), .MSG_DEP(DEP), .MSG_WIDTH(MW)) bus ();

   rc4_key_search_ctrl #(
      .KEY_WIDTH (KW),
      .KEY_LAST  (KLAST),
      .MSG_DEP   (DEP),
      .MSG_WIDTH (MW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Engine models: done rises three edges after the start pulse is seen and
   // holds until eng_reset or bench reset
   assign startVec = {bus.dec_start, bus.ksa_start, bus.init_start};
   assign bus.init_done = doneVec[0];
   assign bus.ksa_done  = doneVec[1];
   assign bus.dec_done  = doneVec[2];
   always @(posedge clk) begin
      for (int e = 0; e < 3; e++) begin
         if (!reset || bus.eng_reset) begin
            doneVec[e] <= 1'b0;
            engRun[e]  <= 1'b0;
            engCnt[e]  <= 2'd0;
         end else if (startVec[e]) begin
            engRun[e] <= 1'b1;
            engCnt[e] <= 2'd0;
         end else if (engRun[e]) begin
            if (engCnt[e] == 2'd2) begin
               doneVec[e] <= 1'b1;
               engRun[e]  <= 1'b0;
            end else begin
               engCnt[e] <= engCnt[e] + 2'd1;
            end
         end
      end
   end

   function automatic logic [7:0] baseByte(int i);
      int m;
      m = i % 27;
      return (m == 26) ? 8'h20 : 8'(8'h61 + m);
   endfunction

   // Plaintext model: a readable message, with badVal planted at badIdx for
   // every key other than validKey
   always @* begin
      for (int i = 0; i < DEP; i++) begin
         bus.decrypted_output[i] = baseByte(i);
      end
      if (int'(bus.secret_key) != validKey) begin
         bus.decrypted_output[badIdx] = badVal;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Raise start for one edge; returns at the following negedge
   task automatic applyStimulus();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic doReset();
      @(negedge clk);
      reset = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
   endtask

   // Monitor the running search until found/exhausted (or first eng_reset when
   // stopOnReject), counting pulses and CHECK cycles; keys at each init_start
   // are compared with keyQ
   task automatic runSearch(input bit stopOnReject, input int budget);
      logic [KW-1:0] ek;
      nInit = 0; nKsa = 0; nDec = 0; nEngRst = 0; nCheck = 0; nOverlap = 0;
      finished = 1'b0;
      for (int c = 0; c < budget && !finished; c++) begin
         if (bus.init_start) begin
            nInit++;
            if (keyQ.size() > 0) begin
               ek = keyQ.pop_front();
               checkOutput("key_at_init_start", 32'(bus.secret_key), 32'(ek));
            end
         end
         if (bus.ksa_start) nKsa++;
         if (bus.dec_start) nDec++;
         if (bus.eng_reset && (|startVec)) nOverlap++;
         if (bus.busy && bus.mem_sel == SEL_NONE && !bus.eng_reset) nCheck++;
         if (bus.eng_reset) begin
            nEngRst++;
            if (stopOnReject) finished = 1'b1;
         end
         if (bus.found || bus.exhausted) finished = 1'b1;
         if (!finished) @(negedge clk);
      end
      checkOutput("search_completes_in_budget", 32'(finished), 32'd1);
      checkOutput("no_eng_reset_with_start", 32'(nOverlap), 32'd0);
   endtask

   initial begin
      exp_t  ex;
      int    waited;
      checks = 0; failures = 0;
      validKey = 0; badIdx = 0; badVal = 8'h60;
      reset = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      checkOutput("rst_init_start", 32'(bus.init_start), 32'd0);
      checkOutput("rst_ksa_start", 32'(bus.ksa_start), 32'd0);
      checkOutput("rst_dec_start", 32'(bus.dec_start), 32'd0);
      checkOutput("rst_eng_reset", 32'(bus.eng_reset), 32'd1);
      checkOutput("rst_mem_sel", 32'(bus.mem_sel), 32'(SEL_NONE));
      checkOutput("rst_key", 32'(bus.secret_key), 32'd0);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_found", 32'(bus.found), 32'd0);
      checkOutput("rst_exhausted", 32'(bus.exhausted), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("eng_reset_drops_after_reset", 32'(bus.eng_reset), 32'd0);

      // Start timing: init_start and mem_sel together, one cycle only
      applyStimulus();
      checkOutput("start_init_pulse", 32'(bus.init_start), 32'd1);
      checkOutput("start_mem_sel", 32'(bus.mem_sel), 32'(SEL_INIT));
      checkOutput("start_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      checkOutput("init_pulse_one_cycle", 32'(bus.init_start), 32'd0);
      checkOutput("wait_init_mem_sel", 32'(bus.mem_sel), 32'(SEL_INIT));
      doReset();

      // Valid at key 0
      validKey = 0;
      keyQ.push_back(24'd0);
      applyStimulus();
      runSearch(1'b0, 2000);
      checkOutput("k0_found", 32'(bus.found), 32'd1);
      checkOutput("k0_key", 32'(bus.secret_key), 32'd0);
      checkOutput("k0_init_count", 32'(nInit), 32'd1);
      checkOutput("k0_ksa_count", 32'(nKsa), 32'd1);
      checkOutput("k0_dec_count", 32'(nDec), 32'd1);
      checkOutput("k0_eng_reset_count", 32'(nEngRst), 32'd0);
      checkOutput("k0_check_cycles", 32'(nCheck), 32'd32);
      checkOutput("k0_busy", 32'(bus.busy), 32'd0);
      doReset();

      // Valid only at key 5, which is also the last key
      validKey = 5;
      for (int i = 0; i <= 5; i++) keyQ.push_back(KW'(i));
      applyStimulus();
      runSearch(1'b0, 2000);
      checkOutput("k5_found", 32'(bus.found), 32'd1);
      checkOutput("k5_key", 32'(bus.secret_key), 32'd5);
      checkOutput("k5_eng_reset_count", 32'(nEngRst), 32'd5);
      checkOutput("k5_exhausted", 32'(bus.exhausted), 32'd0);
      checkOutput("k5_keys_consumed", 32'(keyQ.size()), 32'd0);
      doReset();

      // Never valid: exhaust at KEY_LAST
      validKey = -1;
      for (int i = 0; i <= 5; i++) keyQ.push_back(KW'(i));
      applyStimulus();
      runSearch(1'b0, 3000);
      checkOutput("ex_exhausted", 32'(bus.exhausted), 32'd1);
      checkOutput("ex_found", 32'(bus.found), 32'd0);
      checkOutput("ex_key", 32'(bus.secret_key), 32'd5);
      checkOutput("ex_eng_reset_count", 32'(nEngRst), 32'd6);
      checkOutput("ex_busy", 32'(bus.busy), 32'd0);
      // start in EXHAUSTED returns to IDLE; the next start clears the flag
      applyStimulus();
      checkOutput("ex_to_idle_no_pulse", 32'(bus.init_start), 32'd0);
      checkOutput("ex_to_idle_flag_kept", 32'(bus.exhausted), 32'd1);
      applyStimulus();
      checkOutput("restart_init_pulse", 32'(bus.init_start), 32'd1);
      checkOutput("restart_flag_cleared", 32'(bus.exhausted), 32'd0);
      checkOutput("restart_key", 32'(bus.secret_key), 32'd0);
      doReset();

      // Checker boundaries: byte planted at idx for every key
      vecs[0] = '{8'h60, 0,  1'b0, 1};
      vecs[1] = '{8'h7B, 5,  1'b0, 6};
      vecs[2] = '{8'h1F, 10, 1'b0, 11};
      vecs[3] = '{8'h61, 3,  1'b1, 32};
      vecs[4] = '{8'h7A, 31, 1'b1, 32};
      vecs[5] = '{8'h20, 0,  1'b1, 32};
      vecs[6] = '{8'h60, 31, 1'b0, 32};
      vecs[7] = '{8'h41, 7,  1'b0, 8};
      validKey = -1;
      for (int v = 0; v < 8; v++) begin
         badIdx = vecs[v].idx;
         badVal = vecs[v].val;
         expQ.push_back('{vecs[v].expFound, vecs[v].expCheck});
         applyStimulus();
         runSearch(1'b1, 2000);
         ex = expQ.pop_front();
         checkOutput($sformatf("vec%0d_found", v), 32'(bus.found), 32'(ex.expFound));
         checkOutput($sformatf("vec%0d_check_cycles", v), 32'(nCheck), 32'(ex.expCheck));
         doReset();
      end

      // Abort in WAIT_KSA at key 2, same cycle ksa_done is first seen
      validKey = -1; badIdx = 0; badVal = 8'h60;
      applyStimulus();
      waited = 0;
      while (!(bus.secret_key == 24'd2 && bus.ksa_done && bus.mem_sel == SEL_KSA) && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("abort_reached_wait_ksa", 32'(waited < 1000), 32'd1);
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_mem_sel", 32'(bus.mem_sel), 32'(SEL_NONE));
      checkOutput("abort_eng_reset", 32'(bus.eng_reset), 32'd1);
      checkOutput("abort_key", 32'(bus.secret_key), 32'd0);
      nDec = 0; nEngRst = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.dec_start) nDec++;
         if (bus.eng_reset) nEngRst++;
      end
      checkOutput("abort_no_dec_start", 32'(nDec), 32'd0);
      checkOutput("abort_single_eng_reset", 32'(nEngRst), 32'd0);
      checkOutput("abort_stays_idle", 32'(bus.busy), 32'd0);
      doReset();

      // Reset during WAIT_DEC at key 2, then restart from key 0
      applyStimulus();
      waited = 0;
      while (!(bus.secret_key == 24'd2 && bus.mem_sel == SEL_DEC && !bus.dec_start) && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("reset_reached_wait_dec", 32'(waited < 1000), 32'd1);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midrst_eng_reset", 32'(bus.eng_reset), 32'd1);
      checkOutput("midrst_mem_sel", 32'(bus.mem_sel), 32'(SEL_NONE));
      checkOutput("midrst_key", 32'(bus.secret_key), 32'd0);
      checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
      checkOutput("midrst_starts", 32'(startVec), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      validKey = 1;
      keyQ.push_back(24'd0);
      keyQ.push_back(24'd1);
      applyStimulus();
      runSearch(1'b0, 2000);
      checkOutput("midrst_found", 32'(bus.found), 32'd1);
      checkOutput("midrst_found_key", 32'(bus.secret_key), 32'd1);
      checkOutput("midrst_eng_reset_count", 32'(nEngRst), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
